uop_arbiter: RTL
================

// Module: uop_arbiter
// PURPOSE
//  Merges N_REQ resolved micro-op streams into the matcher's single in_v/in_r input.
//  Typical sources: market-data ITCH decoder, local order entry, cancel engine.
//  Grant policy:
//   - strict priority class (PRIO_MASK) first;
//   - round-robin within a class;
//   - anti-starvation promotion of long-waiting low-priority requesters.
//  Output is one registered slot, so the matcher sees a timing-clean interface.
// PARAMETERS
//  PRICE_W     48  price field width
//  QTY_W       32  quantity field width
//  N_REQ       4   number of requester ports (2..8)
//  PRIO_MASK   'b0001  bit i=1 -> requester i is high-priority class
//  STARVE_MAX  16  wait cycles before a low-priority requester is promoted (>=1)
// PORTS
//  clk          in   1                clock
//  rstn         in   1                async active-low reset
//  req_v        in   N_REQ            per-requester op valid
//  req_r        out  N_REQ            per-requester accept
//  req_opcode   in   3*N_REQ          flattened opcodes, requester i at [3i+:3]
//  req_side     in   N_REQ            0=bid, 1=ask
//  req_price    in   PRICE_W*N_REQ    flattened limit prices
//  req_qty      in   QTY_W*N_REQ      flattened quantities
//  out_v        out  1                slot valid toward matcher
//  out_r        in   1                matcher ready
//  out_opcode   out  3                granted opcode
//  out_side     out  1                granted side
//  out_price    out  PRICE_W          granted price
//  out_qty      out  QTY_W            granted quantity
//  out_src      out  $clog2(N_REQ)    index of requester that supplied the slot
// BEHAVIOUR
//  Reset (async, rstn=0):
//   - out_v=0; out_opcode/side/price/qty/out_src=0; rr_ptr=0; all starve counters=0.
//   - req_r is combinational and reads 0 while out_v=0 and no req_v is high.
//  Handshakes:
//   - A transfer occurs on a cycle with v&&r.
//   - Requester payload must hold stable while req_v && !req_r.
//   - Slot payload holds stable while out_v && !out_r.
//  Slot:
//   - can_load = !out_v || out_r, so back-to-back grants give full throughput.
//   - On load: payload and out_src are registered, out_v<=1.
//   - Latency: req accept -> out_v is 1 cycle.
//   - If out_v && out_r && no grant: out_v<=0.
//  Grant (combinational, one-hot or zero):
//   - eff_hi[i] = PRIO_MASK[i] | (starve[i]==STARVE_MAX).
//   - If any req_v&eff_hi: pick the first such index at or after rr_ptr, modulo N_REQ.
//   - Otherwise apply the same search over plain req_v.
//   - req_r[i] = grant[i] && can_load.
//  rr_ptr:
//   - On each accepted grant to i: rr_ptr <= (i+1) mod N_REQ.
//   - Single pointer, shared by both classes.
//  Starvation counters (per requester, saturating at STARVE_MAX):
//   - Cleared when req_v[i]=0 or req_r[i]=1.
//   - Otherwise incremented each cycle, including cycles where can_load=0.
//   - A promoted requester remains promoted until accepted.
//   - Ties among promoted/high requesters are resolved by rr_ptr.
//  Boundaries:
//   - All req_v low: no grants, counters clear, pointer holds.
//   - Matcher stalled (out_r=0, out_v=1): no req_r asserted, counters of waiting requesters advance.
//   - Single requester: granted every cycle can_load=1.
//   - Reset mid-transfer: slot contents dropped, out_v=0 next edge; no partial op emitted.
//   - Opcodes pass through unchanged (NOP=0, ADD=1, EXECUTE=4 included); no interpretation.
// TESTING
//  1. Reset release, all req_v=0 -> out_v=0, req_r=0, out_src=0 for 10 cycles.
//  2. Only req 2 valid, ADD bid px=1000 qty=50, out_r=1 -> req_r[2]=1 cycle 0; next cycle out_v=1, out_src=2, payload exact.
//  3. req 1,2,3 continuously valid (low-prio), out_r=1 -> accept order 1,2,3,1,2,3; one op per cycle, no bubbles.
//  4. req 0 (high) and req 1 continuously valid, STARVE_MAX=4 -> grants 0,0,0,0,1,0,...; req 1 accepted within 5 cycles of asserting.
//  5. out_r=0 for 8 cycles with slot full, req 3 valid -> out_v and payload stable, req_r all 0; out_r=1 -> req 3 accepted same cycle.
//  6. rstn pulsed low while out_v=1 and out_r=0 -> out_v=0 asynchronously, rr_ptr=0, counters=0; no op delivered.

Source files
------------

// File: rtl/uop_arbiter_if.sv
// Requester-side and matcher-side handshake bundle for uop_arbiter.
// slave: the arbiter; master: requesters plus matcher.
interface uop_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int PRICE_W = 48,
    parameter int QTY_W   = 32
);
    localparam int SW = $clog2(N_REQ);

    logic [N_REQ-1:0]         req_v;
    logic [N_REQ-1:0]         req_r;
    logic [3*N_REQ-1:0]       req_opcode;
    logic [N_REQ-1:0]         req_side;
    logic [PRICE_W*N_REQ-1:0] req_price;
    logic [QTY_W*N_REQ-1:0]   req_qty;
    logic                     out_v;
    logic                     out_r;
    logic [2:0]               out_opcode;
    logic                     out_side;
    logic [PRICE_W-1:0]       out_price;
    logic [QTY_W-1:0]         out_qty;
    logic [SW-1:0]            out_src;

    modport slave (
        input  req_v, req_opcode, req_side, req_price, req_qty, out_r,
        output req_r, out_v, out_opcode, out_side, out_price, out_qty,
        output out_src
    );

    modport master (
        output req_v, req_opcode, req_side, req_price, req_qty, out_r,
        input  req_r, out_v, out_opcode, out_side, out_price, out_qty,
        input  out_src
    );
endinterface

// File: rtl/uop_arbiter.sv
// Merges N_REQ micro-op streams into one registered slot toward the matcher.
// Priority class first, round-robin within class, starvation promotion.
module uop_arbiter #(
    parameter int               PRICE_W    = 48,
    parameter int               QTY_W      = 32,
    parameter int               N_REQ      = 4,
    parameter logic [N_REQ-1:0] PRIO_MASK  = 'b0001,
    parameter int               STARVE_MAX = 16
) (
    input logic         clk,
    input logic         rstn,
    uop_arbiter_if.slave bus
);
    localparam int SW = $clog2(N_REQ);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0]    rr_ptr;
    logic [SW-1:0]    sel;
    logic [CW-1:0]    starve [N_REQ];
    logic [N_REQ-1:0] eff_hi;
    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] grant;
    logic             can_load;
    logic             accept;
    int               idx;

    always_comb begin
        can_load = !bus.out_v || bus.out_r;
        for (int i = 0; i < N_REQ; i++) begin
            eff_hi[i] = PRIO_MASK[i] | (starve[i] == CW'(STARVE_MAX));
        end
        cand  = (|(bus.req_v & eff_hi)) ? (bus.req_v & eff_hi) : bus.req_v;
        grant = '0;
        sel   = '0;
        idx   = 0;
        // First candidate at or after rr_ptr, wrapping modulo N_REQ.
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (grant == '0 && cand[idx]) begin
                grant[idx] = 1'b1;
                sel        = SW'(idx);
            end
        end
        accept    = (|grant) && can_load;
        bus.req_r = grant & {N_REQ{can_load}};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.out_v      <= 1'b0;
            bus.out_opcode <= '0;
            bus.out_side   <= 1'b0;
            bus.out_price  <= '0;
            bus.out_qty    <= '0;
            bus.out_src    <= '0;
            rr_ptr         <= '0;
        end else if (accept) begin
            bus.out_v      <= 1'b1;
            bus.out_opcode <= bus.req_opcode[3*int'(sel) +: 3];
            bus.out_side   <= bus.req_side[sel];
            bus.out_price  <= bus.req_price[PRICE_W*int'(sel) +: PRICE_W];
            bus.out_qty    <= bus.req_qty[QTY_W*int'(sel) +: QTY_W];
            bus.out_src    <= sel;
            rr_ptr         <= (int'(sel) == N_REQ - 1) ? '0 : sel + SW'(1);
        end else if (bus.out_r) begin
            bus.out_v      <= 1'b0;
        end
    end

    // Counters also advance while the slot is stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_REQ; i++) starve[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!bus.req_v[i] || bus.req_r[i])
                    starve[i] <= '0;
                else if (starve[i] != CW'(STARVE_MAX))
                    starve[i] <= starve[i] + CW'(1);
            end
        end
    end
endmodule
